// File: rtl/draw_paddle.sv
// draw_paddle: streams the paddle band column-major, FG inside the clamped span, BG elsewhere.
// Optional DRAW_PADDLE_DIRTY_EN limits each redraw to the columns spanned by old and new paddle.
module draw_paddle #(
    parameter int         SCREEN_W = 120,
    parameter int         PAD_W    = 7,
    parameter int         PAD_H    = 3,
    parameter int         ROW_Y    = 112,
    parameter int         X_W      = 8,
    parameter int         Y_W      = 7,
    parameter logic [2:0] FG_COLOR = 3'b001,
    parameter logic [2:0] BG_COLOR = 3'b000
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [X_W-1:0] position,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     color,
    output logic           plot,
    output logic           busy,
    output logic           done
);
    localparam logic [X_W:0]   HW        = (X_W+1)'(PAD_W / 2);
    localparam logic [X_W:0]   C_MAX     = (X_W+1)'(SCREEN_W - 1 - PAD_W / 2);
    localparam logic [X_W:0]   COL_LAST  = (X_W+1)'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] ROW_FIRST = Y_W'(ROW_Y);
    localparam logic [Y_W-1:0] ROW_LAST  = Y_W'(ROW_Y + PAD_H - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t         state, state_next;
    logic [X_W:0]   c, c_next, last, last_next;
    logic [X_W:0]   pos_w, clamped, first_col, last_col, col_next;
    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_next;
    logic [2:0]     color_next;
    logic           plot_next, busy_next, done_next;
`ifdef DRAW_PADDLE_DIRTY_EN
    logic [X_W:0]   p, p_next;
    logic           valid, valid_next;
`endif

    // Widened by one bit so c-h never underflows.
    function automatic logic [2:0] pix(input logic [X_W:0] col, input logic [X_W:0] cc);
        return (col + HW >= cc && col <= cc + HW) ? FG_COLOR : BG_COLOR;
    endfunction

    always_comb begin
        pos_w   = {1'b0, position};
        clamped = pos_w < HW ? HW : pos_w > C_MAX ? C_MAX : pos_w;
`ifdef DRAW_PADDLE_DIRTY_EN
        first_col  = valid ? (p < clamped ? p : clamped) - HW : '0;
        last_col   = valid ? (p > clamped ? p : clamped) + HW : COL_LAST;
        p_next     = p;
        valid_next = valid;
`else
        first_col = '0;
        last_col  = COL_LAST;
`endif
        state_next = state;
        c_next     = c;
        last_next  = last;
        x_next     = x;
        y_next     = y;
        color_next = color;
        plot_next  = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        col_next   = {1'b0, x};
        case (state)
            IDLE: if (start) begin
                state_next = SCAN;
                c_next     = clamped;
                last_next  = last_col;
                x_next     = first_col[X_W-1:0];
                y_next     = ROW_FIRST;
                color_next = pix(first_col, clamped);
                plot_next  = 1'b1;
                busy_next  = 1'b1;
            end
            SCAN: if ({1'b0, x} == last && y == ROW_LAST) begin
                state_next = DONE;
                done_next  = 1'b1;
`ifdef DRAW_PADDLE_DIRTY_EN
                p_next     = c;
                valid_next = 1'b1;
`endif
            end else begin
                plot_next  = 1'b1;
                busy_next  = 1'b1;
                col_next   = y == ROW_LAST ? {1'b0, x} + 1'b1 : {1'b0, x};
                y_next     = y == ROW_LAST ? ROW_FIRST : y + 1'b1;
                x_next     = col_next[X_W-1:0];
                color_next = pix(col_next, c);
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            c     <= '0;
            last  <= '0;
            x     <= '0;
            y     <= '0;
            color <= '0;
            plot  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef DRAW_PADDLE_DIRTY_EN
            p     <= '0;
            valid <= 1'b0;
`endif
        end else begin
            state <= state_next;
            c     <= c_next;
            last  <= last_next;
            x     <= x_next;
            y     <= y_next;
            color <= color_next;
            plot  <= plot_next;
            busy  <= busy_next;
            done  <= done_next;
`ifdef DRAW_PADDLE_DIRTY_EN
            p     <= p_next;
            valid <= valid_next;
`endif
        end
    end
endmodule

// File: doc/draw_paddle.md
Name: draw_paddle

Overview:
- Parametrised renderer for the player's horizontal paddle (catcher) band.
- On a start pulse, latches the mouse x-position and streams one pixel per clock to the VGA plotter: foreground inside the paddle span, background elsewhere in the band.
- Paddle size, band row, colours and screen width are generics; out-of-range positions are clamped.
- Sits between the mouse tracker and the top-level draw arbiter.

Parameters:
- SCREEN_W, 120, visible columns scanned (0..SCREEN_W-1).
- PAD_W, 7, paddle width in pixels; must be odd, at least 1, and at most SCREEN_W.
- PAD_H, 3, paddle height in rows.
- ROW_Y, 112, top row of the paddle band.
- X_W, 8, width of the position and x buses.
- Y_W, 7, width of the y bus.
- FG_COLOR, 3'b001, paddle colour.
- BG_COLOR, 3'b000, erase colour.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a redraw; sampled only in IDLE.
- position  in  X_W  paddle centre column from the mouse tracker.
- x  out  X_W  pixel column.
- y  out  Y_W  pixel row.
- color  out  3  pixel colour.
- plot  out  1  pixel valid / VGA write enable.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting reset low forces state IDLE and x=0, y=0, color=0, plot=0, busy=0, done=0, all counters 0, at any time, including mid-scan.
  - A scan interrupted by reset is abandoned, not resumed.
- States: IDLE -> SCAN -> DONE -> IDLE.
- IDLE:
  - plot=0, busy=0.
  - start=1 at edge N latches the clamped centre c and enters SCAN.
- Clamping:
  - h = PAD_W/2.
  - c = h if position < h.
  - c = SCREEN_W-1-h if position > SCREEN_W-1-h.
  - Otherwise c = position.
  - Comparisons are done with X_W+1 bits, so there is no unsigned underflow.
- SCAN, outputs registered:
  - The first pixel is valid in cycle N+1. plot=1 and busy=1 on every SCAN cycle.
  - Order: column-major. For col = 0..SCREEN_W-1, row = ROW_Y..ROW_Y+PAD_H-1, with row in the inner loop.
  - color = FG_COLOR if c-h <= col <= c+h, else BG_COLOR.
  - The scan is exactly SCREEN_W*PAD_H pixels with no gaps or repeats.
- DONE:
  - Entered on the cycle after the last pixel: plot=0, busy=0, done=1 for exactly one cycle.
  - Returns to IDLE on the next cycle.
  - Default parameters: done is high at cycle N+1+360.
- start is ignored while busy or in DONE; it is not queued.
- position changes during a scan have no effect; only the latched c is used.
- Start asserted in the IDLE cycle immediately after DONE begins a new scan normally.
- x and y hold their last values when plot=0.

Optional Feature:
- Macro: DRAW_PADDLE_DIRTY_EN.
- When defined:
  - The block keeps the previously drawn centre p and a valid flag; valid is cleared by reset.
  - If valid=1, only columns min(p,c)-h .. max(p,c)+h are scanned, with the same row order and colour rule.
  - Pixel count = (max(p,c)-min(p,c)+PAD_W)*PAD_H.
  - If valid=0, a full scan is performed.
  - p <= c and valid <= 1 on entry to DONE.
- When undefined: every request is a full scan, and no p or valid storage exists.

Test Plan:
- Defaults, reset released, start with position=60: 360 consecutive plot cycles starting at N+1. Columns 57..63 carry color 001 on rows 112..114; all other columns carry 000. done pulses once at N+361.
- position=0: clamped to c=3, so columns 0..6 are FG. position=119: clamped to c=116, so columns 113..119 are FG. No wrap-around FG at the opposite edge.
- start held high for 400 cycles: exactly one scan of 360 pixels, then a second scan starts in the IDLE cycle after done. position toggled mid-scan does not alter colours.
- reset driven low at pixel 100: all outputs are 0 asynchronously. After release, no plot occurs until the next start, and the next start gives a full 360-pixel scan.
- Parameters SCREEN_W=160, PAD_W=11, PAD_H=2, ROW_Y=100, position=80: 320 pixels; columns 75..85 FG on rows 100..101.
- DRAW_PADDLE_DIRTY_EN: first start at position=60 gives 360 pixels. Next start at position=62 scans columns 57..65 only (27 pixels): 57..58 BG, 59..65 FG. done follows 27 cycles after the first pixel.
